// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
//
// Registered N-channel multiplexer with a valid/ready output stage. Each
// accepted beat picks one channel of in_bus. The channel comes either from the
// sel input (direct mode) or from an internal round-robin scan pointer (scan
// mode). The selected slice is registered, together with its channel index and
// an error flag. The error flag marks a direct select that names a channel
// which does not exist; such a beat carries zero data.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   in_bus     in   WIDTH*CHANNELS packed data, channel k at [k*WIDTH +: WIDTH]
//   sel        in   SEL_W direct-mode channel select
//   mode       in   0 = direct select, 1 = round-robin scan
//   scan_clr   in   synchronous clear of the scan pointer
//   in_valid   in   request to capture one beat
//   in_ready   out  a beat can be accepted this cycle
//   out        out  WIDTH registered selected data
//   out_ch     out  SEL_W channel index that produced out
//   out_err    out  beat carried an out-of-range direct select
//   out_valid  out  out/out_ch/out_err hold a valid beat
//   out_ready  in   downstream accepts the current beat
// ---------------------------------------------------------------------------
module mux_n_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      scan_clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Channel count and last channel expressed in the select domain. The count
  // carries one extra bit because CHANNELS can equal 2**SEL_W.
  localparam logic [SEL_W:0]   ChCount = CHANNELS[SEL_W:0];
  localparam logic [SEL_W-1:0] LastCh  = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] r_outData;
  logic [SEL_W-1:0] r_outCh;
  logic             r_outErr;
  logic             r_outValid;
  logic [SEL_W-1:0] r_scanPtr;

  logic             w_ready;
  logic             w_accept;
  logic [SEL_W-1:0] w_ch;
  logic             w_inRange;
  logic [WIDTH-1:0] w_sliceData;

  // The output register can take a new beat when it is empty or when its
  // current beat leaves in this same cycle. This gives one beat per cycle.
  assign w_ready  = !r_outValid || out_ready;
  assign w_accept = in_valid && w_ready && !reset;

  // Pick the effective channel. In scan mode the pointer is always in range.
  // In direct mode sel may point past the last channel when CHANNELS is not a
  // power of two.
  assign w_ch      = mode ? r_scanPtr : sel;
  assign w_inRange = ({1'b0, w_ch} < ChCount);

  // Decode the selected slice with an explicit compare per channel. An
  // index that names no channel matches nothing, so the data falls back to
  // zero.
  always_comb begin
    w_sliceData = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_ch == SEL_W'(k)) begin
        w_sliceData = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage. An accepted beat always overwrites the register. If no beat
  // is accepted, a beat that the downstream takes only drops valid. The data
  // fields keep their last value so a late reader still sees them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outData  <= '0;
      r_outCh    <= '0;
      r_outErr   <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_accept) begin
      r_outData  <= w_inRange ? w_sliceData : '0;
      r_outCh    <= w_ch;
      r_outErr   <= !w_inRange;
      r_outValid <= 1'b1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Scan pointer. A clear wins over an advance in the same cycle. The beat
  // accepted in that cycle has already used the old pointer value through
  // w_ch. The pointer moves only on beats accepted in scan mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scanPtr <= '0;
    end else if (scan_clr) begin
      r_scanPtr <= '0;
    end else if (w_accept && mode) begin
      r_scanPtr <= (r_scanPtr == LastCh) ? '0 : r_scanPtr + SEL_W'(1);
    end
  end

  assign in_ready  = w_ready;
  assign out       = r_outData;
  assign out_ch    = r_outCh;
  assign out_err   = r_outErr;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_mux_n_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_n_reg
//
// Self-checking bench for mux_n_reg. The bench drives two instances:
//   dut   WIDTH=16, CHANNELS=4, channels 1234/ABCD/0000/FFFF
//   dut3  WIDTH=16, CHANNELS=3, channels 1234/ABCD/0000
// The dut3 instance exercises the out-of-range select.
//
// Each table record holds the inputs for one cycle, the in_ready value
// expected during that cycle, and the outputs expected after the edge.
// Alongside the table, a scoreboard process runs on the falling edge. It
// pushes the beat it predicts whenever it sees a handshake on the input side,
// and it pops and compares that beat when the output side hands it off.
// ---------------------------------------------------------------------------
module tb_mux_n_reg;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic        clr;
    logic        vld;
    logic        ordy;
    logic        expReady;
    logic [15:0] expOut;
    logic [1:0]  expCh;
    logic        expErr;
    logic        expValid;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ch;
    logic        err;
  } beat_t;

  logic        clk;
  logic        reset;
  logic [63:0] inBus;
  logic [1:0]  sel;
  logic        mode;
  logic        scanClr;
  logic        inValid;
  logic        inReady;
  logic [15:0] outData;
  logic [1:0]  outCh;
  logic        outErr;
  logic        outValid;
  logic        outReady;

  logic [47:0] c3InBus;
  logic [1:0]  c3Sel;
  logic        c3Mode;
  logic        c3ScanClr;
  logic        c3InValid;
  logic        c3InReady;
  logic [15:0] c3Out;
  logic [1:0]  c3OutCh;
  logic        c3OutErr;
  logic        c3OutValid;
  logic        c3OutReady;

  logic [15:0] chanData [4];
  int          passCount;
  int          checkCount;
  int          modelPtr;
  beat_t       sbQ[$];
  vec_t        vecs[$];

  mux_n_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (inBus),
    .sel       (sel),
    .mode      (mode),
    .scan_clr  (scanClr),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out       (outData),
    .out_ch    (outCh),
    .out_err   (outErr),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  mux_n_reg #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (c3InBus),
    .sel       (c3Sel),
    .mode      (c3Mode),
    .scan_clr  (c3ScanClr),
    .in_valid  (c3InValid),
    .in_ready  (c3InReady),
    .out       (c3Out),
    .out_ch    (c3OutCh),
    .out_err   (c3OutErr),
    .out_valid (c3OutValid),
    .out_ready (c3OutReady)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the sequence below stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected the sequence to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard. On the falling edge the inputs and the registered outputs are
  // both stable, and together they describe the coming rising edge. The
  // process first checks valid against the queue occupancy. It then retires a
  // beat handed downstream. Last, it predicts a newly accepted beat from the
  // channel table and a private scan pointer.
  always @(negedge clk) begin
    if (reset) begin
      sbQ.delete();
      modelPtr = 0;
    end else begin
      logic  modelReady;
      int    ch;
      beat_t b;
      modelReady = (sbQ.size() == 0) || outReady;
      checkCount++;
      if (outValid === (sbQ.size() != 0)) passCount++;
      else $display("[TB] FAIL sb_valid: got out_valid=%b expected %b", outValid, sbQ.size() != 0);
      if (sbQ.size() != 0 && outReady) begin
        b = sbQ.pop_front();
        checkCount++;
        if (outData === b.data && outCh === b.ch && outErr === b.err) passCount++;
        else $display("[TB] FAIL sb_beat: got out=%h ch=%0d err=%b expected out=%h ch=%0d err=%b",
                      outData, outCh, outErr, b.data, b.ch, b.err);
      end
      if (inValid && modelReady) begin
        ch     = mode ? modelPtr : int'(sel);
        b.data = chanData[ch];
        b.ch   = 2'(ch);
        b.err  = 1'b0;
        sbQ.push_back(b);
        if (mode) modelPtr = (modelPtr + 1) % 4;
      end
      if (scanClr) modelPtr = 0;
    end
  end

  // Append one record to the stimulus table
  task automatic addVec(input logic rst, input logic md, input logic [1:0] sl, input logic clr,
                        input logic vld, input logic ordy, input logic eRdy,
                        input logic [15:0] eOut, input logic [1:0] eCh, input logic eErr,
                        input logic eValid);
    vec_t v;
    v.rst = rst; v.mode = md; v.sel = sl; v.clr = clr; v.vld = vld; v.ordy = ordy;
    v.expReady = eRdy; v.expOut = eOut; v.expCh = eCh; v.expErr = eErr; v.expValid = eValid;
    vecs.push_back(v);
  endtask

  // Drive one cycle's worth of inputs to the main instance
  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    mode     = v.mode;
    sel      = v.sel;
    scanClr  = v.clr;
    inValid  = v.vld;
    outReady = v.ordy;
  endtask

  // Compare the main instance's registered outputs with one expectation
  task automatic checkOutput(input string name, input logic [15:0] eOut, input logic [1:0] eCh,
                             input logic eErr, input logic eValid);
    checkCount++;
    if (outData === eOut && outCh === eCh && outErr === eErr && outValid === eValid) passCount++;
    else $display("[TB] FAIL %s: got out=%h ch=%0d err=%b valid=%b expected out=%h ch=%0d err=%b valid=%b",
                  name, outData, outCh, outErr, outValid, eOut, eCh, eErr, eValid);
  endtask

  // Compare the combinational in_ready with its expected value
  task automatic checkReady(input string name, input logic eRdy);
    checkCount++;
    if (inReady === eRdy) passCount++;
    else $display("[TB] FAIL %s_ready: got in_ready=%b expected %b", name, inReady, eRdy);
  endtask

  // Run one record. The task is entered just after a rising edge and leaves
  // just after the next one, so consecutive records form back-to-back cycles.
  task automatic runVec(input vec_t v, input string name);
    applyStimulus(v);
    #1;
    checkReady(name, v.expReady);
    @(posedge clk);
    #1;
    checkOutput(name, v.expOut, v.expCh, v.expErr, v.expValid);
  endtask

  // One cycle on the three-channel instance, then compare its outputs
  task automatic runC3(input string name, input logic md, input logic [1:0] sl, input logic vld,
                       input logic [15:0] eOut, input logic [1:0] eCh, input logic eErr,
                       input logic eValid);
    c3Mode    = md;
    c3Sel     = sl;
    c3InValid = vld;
    @(posedge clk);
    #1;
    checkCount++;
    if (c3Out === eOut && c3OutCh === eCh && c3OutErr === eErr && c3OutValid === eValid) passCount++;
    else $display("[TB] FAIL %s: got out=%h ch=%0d err=%b valid=%b expected out=%h ch=%0d err=%b valid=%b",
                  name, c3Out, c3OutCh, c3OutErr, c3OutValid, eOut, eCh, eErr, eValid);
  endtask

  // Main sequence: reset, table, hand-written corner cases, three-channel checks
  initial begin
    passCount   = 0;
    checkCount  = 0;
    modelPtr    = 0;
    chanData[0] = 16'h1234;
    chanData[1] = 16'hABCD;
    chanData[2] = 16'h0000;
    chanData[3] = 16'hFFFF;
    inBus       = {16'hFFFF, 16'h0000, 16'hABCD, 16'h1234};
    c3InBus     = {16'h0000, 16'hABCD, 16'h1234};
    reset = 1'b1; mode = 1'b0; sel = 2'd0; scanClr = 1'b0; inValid = 1'b0; outReady = 1'b1;
    c3Mode = 1'b0; c3Sel = 2'd0; c3ScanClr = 1'b0; c3InValid = 1'b0; c3OutReady = 1'b1;

    // Direct select, drain, back-to-back, one stall
    //     rst mode sel  clr vld ordy rdy out       ch   err valid
    addVec(0,  0,   2'd1, 0,  1,  1,   1,  16'hABCD, 2'd1, 0,  1);
    addVec(0,  0,   2'd1, 0,  0,  1,   1,  16'hABCD, 2'd1, 0,  0);
    addVec(0,  0,   2'd3, 0,  1,  1,   1,  16'hFFFF, 2'd3, 0,  1);
    addVec(0,  0,   2'd2, 0,  1,  1,   1,  16'h0000, 2'd2, 0,  1);
    addVec(0,  0,   2'd0, 0,  1,  0,   0,  16'h0000, 2'd2, 0,  1);
    addVec(0,  0,   2'd0, 0,  1,  1,   1,  16'h1234, 2'd0, 0,  1);
    addVec(0,  0,   2'd0, 0,  0,  1,   1,  16'h1234, 2'd0, 0,  0);
    // Scan wrap: six beats starting from pointer 0
    addVec(0,  1,   2'd0, 0,  1,  1,   1,  16'h1234, 2'd0, 0,  1);
    addVec(0,  1,   2'd0, 0,  1,  1,   1,  16'hABCD, 2'd1, 0,  1);
    addVec(0,  1,   2'd0, 0,  1,  1,   1,  16'h0000, 2'd2, 0,  1);
    addVec(0,  1,   2'd0, 0,  1,  1,   1,  16'hFFFF, 2'd3, 0,  1);
    addVec(0,  1,   2'd0, 0,  1,  1,   1,  16'h1234, 2'd0, 0,  1);
    addVec(0,  1,   2'd0, 0,  1,  1,   1,  16'hABCD, 2'd1, 0,  1);
    addVec(0,  1,   2'd0, 0,  0,  1,   1,  16'hABCD, 2'd1, 0,  0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 16'h0000, 2'd0, 1'b0, 1'b0);
    checkReady("reset_state", 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: pointer cleared, one beat, three stall cycles during
    // which mode and sel move without effect, then release
    vecs.delete();
    addVec(0, 1, 2'd0, 1, 0, 1, 1, 16'hABCD, 2'd1, 0, 0);
    addVec(0, 1, 2'd0, 0, 1, 1, 1, 16'h1234, 2'd0, 0, 1);
    addVec(0, 1, 2'd0, 0, 1, 0, 0, 16'h1234, 2'd0, 0, 1);
    addVec(0, 0, 2'd3, 0, 1, 0, 0, 16'h1234, 2'd0, 0, 1);
    addVec(0, 1, 2'd2, 0, 1, 0, 0, 16'h1234, 2'd0, 0, 1);
    addVec(0, 1, 2'd0, 0, 1, 1, 1, 16'hABCD, 2'd1, 0, 1);
    addVec(0, 1, 2'd0, 0, 0, 1, 1, 16'hABCD, 2'd1, 0, 0);
    // Clear: two beats, then a clear together with a beat
    addVec(0, 1, 2'd0, 1, 0, 1, 1, 16'hABCD, 2'd1, 0, 0);
    addVec(0, 1, 2'd0, 0, 1, 1, 1, 16'h1234, 2'd0, 0, 1);
    addVec(0, 1, 2'd0, 0, 1, 1, 1, 16'hABCD, 2'd1, 0, 1);
    addVec(0, 1, 2'd0, 1, 1, 1, 1, 16'h0000, 2'd2, 0, 1);
    addVec(0, 1, 2'd0, 0, 1, 1, 1, 16'h1234, 2'd0, 0, 1);
    // Reset during a stall that holds FFFF, then a scan beat after release
    addVec(0, 0, 2'd3, 0, 1, 1, 1, 16'hFFFF, 2'd3, 0, 1);
    addVec(0, 0, 2'd1, 0, 1, 0, 0, 16'hFFFF, 2'd3, 0, 1);
    addVec(1, 1, 2'd2, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 0);
    addVec(0, 1, 2'd0, 0, 1, 1, 1, 16'h1234, 2'd0, 0, 1);
    addVec(0, 1, 2'd0, 0, 0, 1, 1, 16'h1234, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], $sformatf("seq%0d", i));
    end

    // Three-channel instance: out-of-range select, a normal select, and a
    // scan that wraps after channel 2
    runC3("c3_err",   1'b0, 2'd3, 1'b1, 16'h0000, 2'd3, 1'b1, 1'b1);
    runC3("c3_sel1",  1'b0, 2'd1, 1'b1, 16'hABCD, 2'd1, 1'b0, 1'b1);
    runC3("c3_scan0", 1'b1, 2'd3, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b1);
    runC3("c3_scan1", 1'b1, 2'd3, 1'b1, 16'hABCD, 2'd1, 1'b0, 1'b1);
    runC3("c3_scan2", 1'b1, 2'd3, 1'b1, 16'h0000, 2'd2, 1'b0, 1'b1);
    runC3("c3_wrap",  1'b1, 2'd3, 1'b1, 16'h1234, 2'd0, 1'b0, 1'b1);
    runC3("c3_drain", 1'b1, 2'd3, 1'b0, 16'h1234, 2'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
